// File: rtl/plugboard_matrix.sv
// Enigma plugboard: run-time programmable involutive letter-swap table with two
// independent registered lookup channels (front pass A, rear pass B).
module plugboard_matrix #(
  parameter int unsigned LETTERS   = 26,
  parameter int unsigned MAX_PAIRS = 10,
  parameter int unsigned CNT_W     = 4
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               prog_mode,
  input  logic               prog_valid,
  input  logic [LETTERS-1:0] prog_in,
  input  logic               clear,
  input  logic               a_valid,
  input  logic [LETTERS-1:0] a_in,
  input  logic               b_valid,
  input  logic [LETTERS-1:0] b_in,
  output logic [LETTERS-1:0] a_out,
  output logic               a_out_valid,
  output logic [LETTERS-1:0] b_out,
  output logic               b_out_valid,
  output logic [1:0]         lookup_err,
  output logic               pending,
  output logic [CNT_W-1:0]   pair_count,
  output logic               prog_err
);

  localparam int unsigned IDX_W = $clog2(LETTERS);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  function automatic logic is_onehot(input logic [LETTERS-1:0] v);
    return (v != '0) && ((v & (v - LETTERS'(1))) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] encode(input logic [LETTERS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < LETTERS; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   first_q, first_d;
  logic [IDX_W-1:0]   partner_q [LETTERS];
  logic [IDX_W-1:0]   partner_d [LETTERS];
  logic [CNT_W-1:0]   pair_count_q, pair_count_d;
  logic               prog_err_q, prog_err_d;
  logic [LETTERS-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
  logic               a_out_valid_q, a_out_valid_d, b_out_valid_q, b_out_valid_d;
  logic [1:0]         lookup_err_q, lookup_err_d;

  logic               a_ok, b_ok, p_ok, p_paired;
  logic [IDX_W-1:0]   a_idx, b_idx, p_idx;

  assign a_ok     = is_onehot(a_in);
  assign b_ok     = is_onehot(b_in);
  assign p_ok     = is_onehot(prog_in);
  assign a_idx    = encode(a_in);
  assign b_idx    = encode(b_in);
  assign p_idx    = encode(prog_in);
  assign p_paired = partner_q[p_idx] != p_idx;

  // Lookups read partner_q, so a same-cycle commit or clear is not yet visible.
  always_comb begin
    a_out_d       = a_out_q;
    b_out_d       = b_out_q;
    a_out_valid_d = a_valid;
    b_out_valid_d = b_valid;
    lookup_err_d  = lookup_err_q;
    if (a_valid) begin
      a_out_d         = a_ok ? (LETTERS'(1) << partner_q[a_idx]) : '0;
      lookup_err_d[0] = !a_ok;
    end
    if (b_valid) begin
      b_out_d         = b_ok ? (LETTERS'(1) << partner_q[b_idx]) : '0;
      lookup_err_d[1] = !b_ok;
    end
  end

  // Programming FSM; every table edit touches both halves to keep the involution.
  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    partner_d    = partner_q;
    pair_count_d = pair_count_q;
    prog_err_d   = 1'b0;
    if (clear) begin
      for (int i = 0; i < LETTERS; i++) partner_d[i] = IDX_W'(i);
      pair_count_d = '0;
      state_d      = IDLE;
    end else if (!prog_mode) begin
      state_d = IDLE;
    end else if (prog_valid) begin
      case (state_q)
        IDLE: begin
          if (!p_ok) begin
            prog_err_d = 1'b1;
          end else if (p_paired) begin
            partner_d[p_idx]            = p_idx;
            partner_d[partner_q[p_idx]] = partner_q[p_idx];
            pair_count_d                = pair_count_q - CNT_W'(1);
          end else if (pair_count_q == CNT_W'(MAX_PAIRS)) begin
            prog_err_d = 1'b1;
          end else begin
            first_d = p_idx;
            state_d = PEND;
          end
        end
        PEND: begin
          if (p_ok && p_idx == first_q) begin
            state_d = IDLE;
          end else if (!p_ok || p_paired) begin
            prog_err_d = 1'b1;
          end else begin
            partner_d[first_q] = p_idx;
            partner_d[p_idx]   = first_q;
            pair_count_d       = pair_count_q + CNT_W'(1);
            state_d            = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      first_q       <= '0;
      for (int i = 0; i < LETTERS; i++) partner_q[i] <= IDX_W'(i);
      pair_count_q  <= '0;
      prog_err_q    <= 1'b0;
      a_out_q       <= '0;
      b_out_q       <= '0;
      a_out_valid_q <= 1'b0;
      b_out_valid_q <= 1'b0;
      lookup_err_q  <= '0;
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      partner_q     <= partner_d;
      pair_count_q  <= pair_count_d;
      prog_err_q    <= prog_err_d;
      a_out_q       <= a_out_d;
      b_out_q       <= b_out_d;
      a_out_valid_q <= a_out_valid_d;
      b_out_valid_q <= b_out_valid_d;
      lookup_err_q  <= lookup_err_d;
    end
  end

  assign a_out       = a_out_q;
  assign b_out       = b_out_q;
  assign a_out_valid = a_out_valid_q;
  assign b_out_valid = b_out_valid_q;
  assign lookup_err  = lookup_err_q;
  assign pending     = state_q == PEND;
  assign pair_count  = pair_count_q;
  assign prog_err    = prog_err_q;

endmodule

// File: doc/plugboard_matrix.md
Name: plugboard_matrix

Overview:
- Programmable Enigma plugboard (steckerbrett) that sits between keyboardu and rero, and between rero and gui.
- Holds up to MAX_PAIRS letter swaps, programmed at run time from one-hot keystrokes.
- Serves two independent lookup channels: A for the front pass (keyboard to rotors) and B for the rear pass (rotors to display).
- Each channel has a registered output with 1-cycle latency; the swap table is an involution, so both channels use the same table.

Parameters:
- LETTERS, 26, alphabet size; width of all one-hot letter buses.
- MAX_PAIRS, 10, maximum number of simultaneously stored swap pairs.
- CNT_W, 4, width of pair_count; must satisfy 2^CNT_W > MAX_PAIRS.

Ports:
- CLOCK_50  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (KEY[0] at top level).
- prog_mode  in  1  1 = keystrokes on prog_in program the table; 0 = programming FSM held in IDLE.
- prog_valid  in  1  single-cycle strobe: prog_in holds a new keystroke.
- prog_in  in  LETTERS  one-hot programming letter.
- clear  in  1  synchronous clear of all pairs.
- a_valid  in  1  channel A lookup request.
- a_in  in  LETTERS  channel A one-hot letter.
- b_valid  in  1  channel B lookup request.
- b_in  in  LETTERS  channel B one-hot letter.
- a_out  out  LETTERS  channel A mapped letter.
- a_out_valid  out  1  channel A result valid.
- b_out  out  LETTERS  channel B mapped letter.
- b_out_valid  out  1  channel B result valid.
- lookup_err  out  2  per channel ([0]=A, [1]=B): input was not exactly one-hot.
- pending  out  1  first letter of a pair captured; waiting for the second.
- pair_count  out  CNT_W  number of stored pairs.
- prog_err  out  1  one-cycle pulse: keystroke rejected.

Behaviour:
- Reset (async assert, sync release): every letter maps to itself. All outputs are 0: a_out, b_out, both valids, lookup_err, pending, pair_count, prog_err. FSM goes to IDLE.
- Table: partner index per letter; an unpaired letter's partner is itself. The table is an involution at all times.
- Lookup, per channel:
  - The cycle after x_valid=1, x_out_valid=1.
  - If the input is exactly one-hot, x_out = one-hot of the partner; otherwise x_out = 0 and lookup_err bit = 1.
  - With x_valid=0, x_out_valid=0 and x_out holds its previous value.
  - Channels are fully independent and may fire in the same cycle.
  - Lookups use the table as it was before any same-cycle commit or clear (old-table semantics).
- FSM, evaluated only on prog_valid && prog_mode:
  - IDLE, non-one-hot prog_in: prog_err pulse, stay in IDLE.
  - IDLE, letter already paired: unplug it (both letters return to self), pair_count-1, stay in IDLE.
  - IDLE, letter unpaired and pair_count==MAX_PAIRS: prog_err, stay in IDLE.
  - IDLE, letter unpaired and room available: latch it as first, go to PEND (pending=1).
  - PEND, prog_in == first: cancel and go to IDLE, no error.
  - PEND, prog_in already paired or not one-hot: prog_err, stay in PEND.
  - PEND, otherwise: commit first<->prog_in, pair_count+1, go to IDLE. New mapping is visible to lookups issued the next cycle.
- prog_mode deasserted while in PEND: return to IDLE and discard first; no error.
- clear: next cycle the table is identity, pair_count=0, FSM in IDLE. clear has priority over a same-cycle prog_valid, and that keystroke is dropped with no error.
- prog_err is high for exactly one cycle per rejected keystroke.
- pair_count never exceeds MAX_PAIRS or goes below 0.
- Reset asserted mid-programming: table and FSM return to reset state immediately.

Test Plan:
- After reset, a_valid with a_in=26'h1 (A) -> next cycle a_out=26'h1, a_out_valid=1, pair_count=0.
- prog_mode=1; strobe A (26'h1) then Q (26'h10000) -> pending 1 then 0, pair_count=1. a_in=A gives a_out=26'h10000; same cycle, b_in=Q gives b_out=26'h1.
- Program 10 pairs (AB CD EF GH IJ KL MN OP QR ST), then strobe U -> prog_err pulse, pair_count stays 10, pending=0.
- With A-Q stored, strobe Q in IDLE -> pair_count decrements; a_in=Q then gives a_out=26'h10000.
- Strobe C, then C again -> pending returns to 0, no prog_err. Strobe C then E with E already paired -> prog_err, pending stays 1.
- a_in=26'h3 -> a_out=0, lookup_err[0]=1. clear asserted with a simultaneous prog_valid -> pair_count=0, table identity, no prog_err.
